meter_peak: RTL and testbench

METER_PEAK -- requirements
Module: meter_peak

---
 rtl/meter_pkg.sv | 14 +
 rtl/meter_abs.sv | 59 +++++
 rtl/meter_peak.sv | 170 +++++++++++++++++
 tb/tb_meter_peak.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/meter_pkg.sv
// rtl/meter_pkg.sv - shared state type and default widths for the peak meter
package meter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } meter_state_e;

    localparam int DEF_SAMPLE_WIDTH = 24;
    localparam int DEF_WORD_WIDTH   = 36;
    localparam int DEF_ADDR_WIDTH   = 10;
    localparam int DEF_N_CHANNELS   = 32;

endpackage

// File: rtl/meter_abs.sv
// rtl/meter_abs.sv - stage 0: registered saturating absolute value of the incoming sample
//
// Ports:
//   clk, reset_n   clock, synchronous active-low reset
//   in_valid_i     sample strobe
//   in_channel_i   channel of the sample
//   in_sample_i    signed sample
//   s0_valid_o     registered strobe
//   s0_channel_o   registered channel
//   s0_abs_o       registered |sample|, SAMPLE_WIDTH-1 bits, saturated
module meter_abs
    import meter_pkg::*;
#(
    parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
    parameter int CH_W         = 5
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid_i,
    input  logic [CH_W-1:0]         in_channel_i,
    input  logic [SAMPLE_WIDTH-1:0] in_sample_i,
    output logic                    s0_valid_o,
    output logic [CH_W-1:0]         s0_channel_o,
    output logic [SAMPLE_WIDTH-2:0] s0_abs_o
);

    logic                    valid_q;
    logic [CH_W-1:0]         channel_q;
    logic [SAMPLE_WIDTH-2:0] abs_q, abs_d;
    logic [SAMPLE_WIDTH-1:0] neg;

    // The most-negative code has no positive twin; clamp it to full scale.
    always_comb begin
        neg   = -in_sample_i;
        abs_d = in_sample_i[SAMPLE_WIDTH-2:0];
        if (in_sample_i == {1'b1, {(SAMPLE_WIDTH-1){1'b0}}}) begin
            abs_d = {(SAMPLE_WIDTH-1){1'b1}};
        end else if (in_sample_i[SAMPLE_WIDTH-1]) begin
            abs_d = neg[SAMPLE_WIDTH-2:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q   <= 1'b0;
            channel_q <= '0;
            abs_q     <= '0;
        end else begin
            valid_q   <= in_valid_i;
            channel_q <= in_channel_i;
            abs_q     <= abs_d;
        end
    end

    assign s0_valid_o   = valid_q;
    assign s0_channel_o = channel_q;
    assign s0_abs_o     = abs_q;

endmodule

// File: rtl/meter_peak.sv
// rtl/meter_peak.sv - per-channel peak meter with frame sweep into meter RAM
//
// Build option: METER_DECAY_EN defined -> sweep writes peak >> DECAY_SHIFT
// (ballistic decay); undefined -> sweep writes 0 (peak-per-frame).
//
// Ports:
//   clk, reset_n     clock, synchronous active-low reset
//   in_valid         sample strobe, no backpressure
//   in_channel       channel of sample
//   in_sample        signed sample
//   frame_tick       pulse starting a meter frame sweep
//   mtr_wr_addr      meter RAM write address
//   mtr_wr_data      meter RAM write data (peak, zero-extended)
//   mtr_wr_enable    meter RAM write strobe
//   sweep_busy       high while sweeping
//   tick_overrun     sticky: frame_tick seen while sweeping
module meter_peak
    import meter_pkg::*;
#(
    parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
    parameter int WORD_WIDTH   = DEF_WORD_WIDTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int N_CHANNELS   = DEF_N_CHANNELS,
    parameter int METER_BASE   = 0,
    parameter int DECAY_SHIFT  = 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          in_valid,
    input  logic [$clog2(N_CHANNELS)-1:0] in_channel,
    input  logic [SAMPLE_WIDTH-1:0]       in_sample,
    input  logic                          frame_tick,
    output logic [ADDR_WIDTH-1:0]         mtr_wr_addr,
    output logic [WORD_WIDTH-1:0]         mtr_wr_data,
    output logic                          mtr_wr_enable,
    output logic                          sweep_busy,
    output logic                          tick_overrun
);

    localparam int CH_W   = $clog2(N_CHANNELS);
    localparam int PEAK_W = SAMPLE_WIDTH - 1;
`ifdef METER_DECAY_EN
    localparam bit DECAY_EN = 1'b1;
`else
    localparam bit DECAY_EN = 1'b0;
`endif
    // Shifting by the full peak width yields zero: the no-decay sweep.
    localparam int SWEEP_SHIFT = DECAY_EN ? DECAY_SHIFT : PEAK_W;

    logic              s0_valid;
    logic [CH_W-1:0]   s0_channel;
    logic [PEAK_W-1:0] s0_abs;

    meter_abs #(
        .SAMPLE_WIDTH (SAMPLE_WIDTH),
        .CH_W         (CH_W)
    ) u_abs (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid_i   (in_valid),
        .in_channel_i (in_channel),
        .in_sample_i  (in_sample),
        .s0_valid_o   (s0_valid),
        .s0_channel_o (s0_channel),
        .s0_abs_o     (s0_abs)
    );

    logic [PEAK_W-1:0]     peak_q [N_CHANNELS];
    meter_state_e          state_q, state_d;
    logic [CH_W-1:0]       idx_q, idx_d;
    logic                  overrun_q, overrun_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [WORD_WIDTH-1:0] wr_data_q, wr_data_d;

    logic                  sweep_do;
    logic                  upd_en;
    logic [CH_W-1:0]       upd_idx;
    logic [PEAK_W-1:0]     upd_val;
    logic [PEAK_W-1:0]     sample_peak;
    logic [PEAK_W-1:0]     sweep_val;

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            overrun_q <= overrun_d;
        end
    end

    // Next state
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        overrun_d = overrun_q;
        case (state_q)
            IDLE: begin
                if (frame_tick) begin
                    state_d = SWEEP;
                    idx_d   = '0;
                end
            end
            SWEEP: begin
                if (frame_tick) overrun_d = 1'b1;
                if (sweep_do) begin
                    if (idx_q == CH_W'(N_CHANNELS - 1)) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: a pending stage-0 sample always wins the single write port,
    // so the sweep only advances on cycles without one.
    always_comb begin
        sweep_do    = (state_q == SWEEP) && !s0_valid;
        sample_peak = (s0_abs > peak_q[s0_channel]) ? s0_abs : peak_q[s0_channel];
        sweep_val   = peak_q[idx_q] >> SWEEP_SHIFT;
        upd_en      = 1'b0;
        upd_idx     = s0_channel;
        upd_val     = sample_peak;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        if (s0_valid) begin
            upd_en    = 1'b1;
            wr_en_d   = 1'b1;
            wr_addr_d = ADDR_WIDTH'(METER_BASE) + ADDR_WIDTH'(s0_channel);
            wr_data_d = WORD_WIDTH'(sample_peak);
        end else if (sweep_do) begin
            upd_en    = 1'b1;
            upd_idx   = idx_q;
            upd_val   = sweep_val;
            wr_en_d   = 1'b1;
            wr_addr_d = ADDR_WIDTH'(METER_BASE) + ADDR_WIDTH'(idx_q);
            wr_data_d = WORD_WIDTH'(sweep_val);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < N_CHANNELS; i++) peak_q[i] <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            if (upd_en) peak_q[upd_idx] <= upd_val;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign mtr_wr_enable = wr_en_q;
    assign mtr_wr_addr   = wr_addr_q;
    assign mtr_wr_data   = wr_data_q;
    assign sweep_busy    = (state_q == SWEEP);
    assign tick_overrun  = overrun_q;

endmodule

// File: tb/tb_meter_peak.sv
// tb/tb_meter_peak.sv - scoreboard bench for meter_peak
module tb_meter_peak;

    localparam int NCH = 32;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [4:0]  in_channel = '0;
    logic [23:0] in_sample = '0;
    logic        frame_tick = 1'b0;
    logic [9:0]  mtr_wr_addr;
    logic [35:0] mtr_wr_data;
    logic        mtr_wr_enable;
    logic        sweep_busy;
    logic        tick_overrun;

    meter_peak dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_channel    (in_channel),
        .in_sample     (in_sample),
        .frame_tick    (frame_tick),
        .mtr_wr_addr   (mtr_wr_addr),
        .mtr_wr_data   (mtr_wr_data),
        .mtr_wr_enable (mtr_wr_enable),
        .sweep_busy    (sweep_busy),
        .tick_overrun  (tick_overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0]  addr;
        logic [35:0] data;
    } wr_t;

    wr_t         sb_q[$];
    int unsigned mpeak [NCH];
    int          n_assert = 0;
    int          n_fail = 0;
    int          busy_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int unsigned sat_abs(input int v);
        if (v == -(1 << 23)) return 32'd8388607;
        return (v < 0) ? -v : v;
    endfunction

    task automatic push_sample(input int ch, input int v);
        int unsigned a;
        a = sat_abs(v);
        if (a > mpeak[ch]) mpeak[ch] = a;
        sb_q.push_back('{addr: 10'(ch), data: 36'(mpeak[ch])});
    endtask

    task automatic push_sweep(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
`ifdef METER_DECAY_EN
            mpeak[i] = mpeak[i] >> 1;
`else
            mpeak[i] = 0;
`endif
            sb_q.push_back('{addr: 10'(i), data: 36'(mpeak[i])});
        end
    endtask

    task automatic send(input int ch, input int v);
        @(negedge clk);
        in_valid   = 1'b1;
        in_channel = 5'(ch);
        in_sample  = 24'(v);
        push_sample(ch, v);
    endtask

    task automatic stop_in();
        @(negedge clk);
        in_valid   = 1'b0;
        frame_tick = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 300; k++) begin
            if (sb_q.size() == 0 && !sweep_busy) break;
            @(negedge clk);
        end
        @(negedge clk);
        chk({tag, "_queue"}, 64'(sb_q.size()), 64'd0);
        chk({tag, "_busy"}, 64'(sweep_busy), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        for (int i = 0; i < NCH; i++) mpeak[i] = 0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Monitor: every write strobe must match the next scoreboard entry.
    always @(negedge clk) begin
        if (sweep_busy) busy_cnt++;
        if (mtr_wr_enable) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_write", 64'(sb_q.size()), 64'd1);
            end else begin
                wr_t e;
                e = sb_q.pop_front();
                chk("sb_addr", 64'(mtr_wr_addr), 64'(e.addr));
                chk("sb_data", 64'(mtr_wr_data), 64'(e.data));
            end
        end
    end

    initial begin
        for (int i = 0; i < NCH; i++) mpeak[i] = 0;

        repeat (3) @(negedge clk);
        chk("rst_wr_enable", 64'(mtr_wr_enable), 64'd0);
        chk("rst_wr_addr", 64'(mtr_wr_addr), 64'd0);
        chk("rst_wr_data", 64'(mtr_wr_data), 64'd0);
        chk("rst_sweep_busy", 64'(sweep_busy), 64'd0);
        chk("rst_tick_overrun", 64'(tick_overrun), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // -1000 on ch 3: strobe two cycles later
        send(3, -1000);
        stop_in();
        chk("lat_early", 64'(mtr_wr_enable), 64'd0);
        @(negedge clk);
        chk("lat_strobe", 64'(mtr_wr_enable), 64'd1);
        chk("lat_addr", 64'(mtr_wr_addr), 64'd3);
        chk("lat_data", 64'(mtr_wr_data), 64'd1000);
        drain("s1");

        // back-to-back same channel
        send(5, 500);
        send(5, 200);
        send(5, 800);
        stop_in();
        drain("b2b");

        // saturation and extremes
        send(7, -(1 << 23));
        send(8, (1 << 23) - 1);
        send(9, 0);
        send(9, -1);
        stop_in();
        drain("sat");

        // frame sweep from a known state
        do_reset();
        send(0, 64);
        send(1, -8);
        stop_in();
        drain("pre_sweep");
        @(negedge clk);
        frame_tick = 1'b1;
        busy_cnt = 0;
        push_sweep(0, NCH - 1);
        stop_in();
        drain("sweep");
        chk("sweep_busy_cycles", 64'(busy_cnt), 64'd32);

        // sample landing on the ch-2 sweep cycle stalls the sweep
        send(2, 300);
        stop_in();
        drain("pre_stall");
        @(negedge clk);
        frame_tick = 1'b1;
        busy_cnt = 0;
        push_sweep(0, 1);
        stop_in();
        send(2, 600);
        push_sweep(2, NCH - 1);
        stop_in();
        drain("stall");
        chk("stall_busy_cycles", 64'(busy_cnt), 64'd33);

        // tick coincident with a sample in IDLE
        @(negedge clk);
        frame_tick = 1'b1;
        in_valid   = 1'b1;
        in_channel = 5'd4;
        in_sample  = 24'd77;
        busy_cnt = 0;
        push_sample(4, 77);
        push_sweep(0, NCH - 1);
        stop_in();
        drain("tick_and_sample");
        chk("coincident_busy_cycles", 64'(busy_cnt), 64'd33);

        // frame_tick during a sweep: overrun, no restart
        chk("overrun_before", 64'(tick_overrun), 64'd0);
        @(negedge clk);
        frame_tick = 1'b1;
        busy_cnt = 0;
        push_sweep(0, NCH - 1);
        stop_in();
        repeat (10) @(negedge clk);
        frame_tick = 1'b1;
        stop_in();
        chk("overrun_set", 64'(tick_overrun), 64'd1);
        drain("overrun");
        chk("overrun_busy_cycles", 64'(busy_cnt), 64'd32);
        chk("overrun_sticky", 64'(tick_overrun), 64'd1);

        // reset in the middle of a sweep
        @(negedge clk);
        frame_tick = 1'b1;
        push_sweep(0, 3);
        stop_in();
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        for (int i = 0; i < NCH; i++) mpeak[i] = 0;
        @(negedge clk);
        chk("midrst_wr_enable", 64'(mtr_wr_enable), 64'd0);
        chk("midrst_wr_addr", 64'(mtr_wr_addr), 64'd0);
        chk("midrst_wr_data", 64'(mtr_wr_data), 64'd0);
        chk("midrst_busy", 64'(sweep_busy), 64'd0);
        chk("midrst_overrun", 64'(tick_overrun), 64'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", 64'(sweep_busy), 64'd0);
        drain("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
